// File: rtl/niu_pkg.sv
// Shared types and constants for the NIU RX packet filter.
// Optional feature: define NIU_RX_BCAST_EN to accept broadcast frames regardless of the MAC table.
package niu_pkg;

  localparam int unsigned MAC_W = 48;
  localparam logic [MAC_W-1:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    DROP
  } rx_state_e;

  typedef enum logic [1:0] {
    DR_NONE,
    DR_BAD,
    DR_FLT,
    DR_OVF
  } drop_reason_e;

  // Reassemble a destination MAC from the low six stream bytes; byte 0 is the first wire octet.
  function automatic logic [MAC_W-1:0] mac_from_sof(input logic [MAC_W-1:0] low_bytes);
    logic [MAC_W-1:0] mac;
    mac = '0;
    for (int j = 0; j < 6; j++) begin
      mac[MAC_W-1-j*8 -: 8] = low_bytes[j*8 +: 8];
    end
    return mac;
  endfunction

endpackage

// File: rtl/niu_rx_pkt_ram.sv
// Simple dual-port frame buffer RAM with a registered read port.
module niu_rx_pkt_ram #(
  parameter  int unsigned DEPTH = 512,
  parameter  int unsigned WIDTH = 73,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/niu_rx_pkt_filter.sv
// Store-and-forward RX frame buffer with destination-MAC filtering and per-frame rewind.
// Optional feature: NIU_RX_BCAST_EN makes FF:FF:FF:FF:FF:FF always match.
module niu_rx_pkt_filter
  import niu_pkg::*;
#(
  parameter  int unsigned DATA_W  = 64,
  parameter  int unsigned DEPTH   = 512,
  parameter  int unsigned NUM_MAC = 4,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned KEEP_W  = DATA_W / 8,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned PTR_W   = AW + 1,
  localparam int unsigned IDX_W   = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1,
  localparam int unsigned RAM_W   = DATA_W + KEEP_W + 1
) (
  input  logic              clk156,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              filter_en,
  input  logic              mac_wr_en,
  input  logic [IDX_W-1:0]  mac_wr_idx,
  input  logic [MAC_W-1:0]  mac_wr_addr,
  input  logic              mac_wr_valid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [PTR_W-1:0]  rd_data_count,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_bad_cnt,
  output logic [CNT_W-1:0]  drop_flt_cnt,
  output logic [CNT_W-1:0]  drop_ovf_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // MAC filter table
  logic [MAC_W-1:0] mac_addr [NUM_MAC];
  logic [NUM_MAC-1:0] mac_valid;

  // Write-side state
  rx_state_e          state;
  drop_reason_e       drop_reason;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_commit;
  logic               ovf;

  // Read-side state
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   fetch_ptr;
  logic               rd_pend;
  logic               skid_valid;
  logic [RAM_W-1:0]   skid_q;
  logic [RAM_W-1:0]   ram_q;

  logic [MAC_W-1:0]   sof_dest_c;
  logic               match_c;
  logic               runt_c;
  logic               full_c;
  logic               storing_c;
  logic               wr_en_c;
  drop_reason_e       drop_reason_c;
  logic               pop_c;
  logic [1:0]         held_c;
  logic               rd_en_c;

  // Table updates; a write in the SOF cycle is seen only by later frames
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      mac_valid <= '0;
      for (int i = 0; i < NUM_MAC; i++) begin
        mac_addr[i] <= '0;
      end
    end else if (mac_wr_en) begin
      mac_addr[mac_wr_idx]  <= mac_wr_addr;
      mac_valid[mac_wr_idx] <= mac_wr_valid;
    end
  end

  // SOF classification: runt, parallel table match, store/drop decision
  always_comb begin
    sof_dest_c = mac_from_sof(s_axis_tdata[MAC_W-1:0]);
    match_c    = 1'b0;
    for (int i = 0; i < NUM_MAC; i++) begin
      if (mac_valid[i] && (mac_addr[i] == sof_dest_c)) begin
        match_c = 1'b1;
      end
    end
`ifdef NIU_RX_BCAST_EN
    if (sof_dest_c == BCAST_ADDR) begin
      match_c = 1'b1;
    end
`endif
    runt_c        = (s_axis_tkeep[5:0] != 6'h3F);
    full_c        = ((wr_ptr - rd_ptr) == PTR_W'(DEPTH));
    storing_c     = (state == STORE) ||
                    ((state == IDLE) && !runt_c && (match_c || !filter_en));
    wr_en_c       = s_axis_tvalid && storing_c && !full_c;
    drop_reason_c = drop_reason;
    if (state == IDLE) begin
      drop_reason_c = runt_c ? DR_BAD : DR_FLT;
    end
  end

  // Frame FSM: store, commit or rewind, and drop accounting
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      drop_reason  <= DR_NONE;
      wr_ptr       <= '0;
      wr_commit    <= '0;
      ovf          <= 1'b0;
      pkt_cnt      <= '0;
      drop_bad_cnt <= '0;
      drop_flt_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else if (s_axis_tvalid) begin
      if (storing_c) begin
        if (wr_en_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (s_axis_tlast) begin
          state <= IDLE;
          ovf   <= 1'b0;
          if (s_axis_tuser) begin
            wr_ptr       <= wr_commit;
            drop_bad_cnt <= sat_inc(drop_bad_cnt);
          end else if (ovf || full_c) begin
            wr_ptr       <= wr_commit;
            drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
          end else begin
            wr_commit <= wr_ptr + PTR_W'(1);
            pkt_cnt   <= sat_inc(pkt_cnt);
          end
        end else begin
          state <= STORE;
          if (full_c) begin
            ovf <= 1'b1;
          end
        end
      end else begin
        if (s_axis_tlast) begin
          state <= IDLE;
          if (s_axis_tuser || (drop_reason_c == DR_BAD)) begin
            drop_bad_cnt <= sat_inc(drop_bad_cnt);
          end else begin
            drop_flt_cnt <= sat_inc(drop_flt_cnt);
          end
        end else begin
          state       <= DROP;
          drop_reason <= drop_reason_c;
        end
      end
    end
  end

  niu_rx_pkt_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk     (clk156),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (rd_en_c),
    .rd_addr (fetch_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  // Prefetch committed words while output reg + skid + in-flight read stay within two entries
  always_comb begin
    pop_c   = m_axis_tvalid && m_axis_tready;
    held_c  = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(rd_pend);
    rd_en_c = (fetch_ptr != wr_commit) && ((held_c - 2'(pop_c)) < 2'd2);
  end

  // Output register with skid; rd_ptr advances only on accepted beats
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      rd_pend       <= 1'b0;
      skid_valid    <= 1'b0;
      skid_q        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      rd_pend <= rd_en_c;
      if (rd_en_c) begin
        fetch_ptr <= fetch_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (pop_c || !m_axis_tvalid) begin
        if (skid_valid) begin
          {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= skid_q;
          m_axis_tvalid <= 1'b1;
          if (rd_pend) begin
            skid_q <= ram_q;
          end else begin
            skid_valid <= 1'b0;
          end
        end else if (rd_pend) begin
          {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_q     <= ram_q;
        skid_valid <= 1'b1;
      end
    end
  end

  assign rd_data_count = wr_commit - rd_ptr;

endmodule

// File: tb/tb_niu_rx_pkt_filter.sv
// Directed bench for niu_rx_pkt_filter (DEPTH=16 so overflow is reachable).
// Broadcast expectations follow NIU_RX_BCAST_EN.
module tb_niu_rx_pkt_filter;
  import niu_pkg::*;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NUM_MAC = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned PTR_W   = 5;
  localparam int unsigned IDX_W   = 2;

  localparam logic [47:0] E0 = 48'h000A_3501_0203;
  localparam logic [47:0] E1 = 48'h0100_5E00_0001;
  localparam logic [47:0] EU = 48'h000A_3509_0909;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

  logic              clk156 = 1'b0;
  logic              aresetn;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tuser;
  logic              filter_en;
  logic              mac_wr_en;
  logic [IDX_W-1:0]  mac_wr_idx;
  logic [47:0]       mac_wr_addr;
  logic              mac_wr_valid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [PTR_W-1:0]  rd_data_count;
  logic [CNT_W-1:0]  pkt_cnt, drop_bad_cnt, drop_flt_cnt, drop_ovf_cnt;

  niu_rx_pkt_filter #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .NUM_MAC (NUM_MAC), .CNT_W (CNT_W)
  ) dut (
    .clk156 (clk156), .aresetn (aresetn),
    .s_axis_tdata (s_axis_tdata), .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid), .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser), .filter_en (filter_en),
    .mac_wr_en (mac_wr_en), .mac_wr_idx (mac_wr_idx),
    .mac_wr_addr (mac_wr_addr), .mac_wr_valid (mac_wr_valid),
    .m_axis_tdata (m_axis_tdata), .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid), .m_axis_tlast (m_axis_tlast),
    .m_axis_tready (m_axis_tready), .rd_data_count (rd_data_count),
    .pkt_cnt (pkt_cnt), .drop_bad_cnt (drop_bad_cnt),
    .drop_flt_cnt (drop_flt_cnt), .drop_ovf_cnt (drop_ovf_cnt)
  );

  always #5 clk156 = ~clk156;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [47:0] dest;
    int          beats;
    logic [7:0]  sof_keep;
    logic [7:0]  last_keep;
    logic        tuser;
    logic        fen;
    logic        pass;
    int          pkt;
    int          bad;
    int          flt;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t got[$];
  beat_t exp_q[$];
  vec_t  vecs[10];

  // Capture accepted output beats; the handshake completes on the next rising edge
  always @(negedge clk156) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      got.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [47:0] dest, input int seed, input int i,
                                    input int n, input logic [7:0] sk, input logic [7:0] lk);
    beat_t b;
    for (int j = 0; j < 8; j++) b.d[j*8 +: 8] = 8'(seed * 37 + i * 8 + j);
    if (i == 0) for (int j = 0; j < 6; j++) b.d[j*8 +: 8] = dest[47-j*8 -: 8];
    b.k = (i == 0) ? sk : ((i == n - 1) ? lk : 8'hFF);
    b.l = (i == n - 1);
    return b;
  endfunction

  // Drive nsend beats of an n-beat frame back-to-back
  task automatic send_frame(input logic [47:0] dest, input int n, input int seed,
                            input logic [7:0] sk, input logic [7:0] lk, input logic tuser,
                            input logic push, input int nsend);
    beat_t b;
    for (int i = 0; i < nsend; i++) begin
      b = mk_beat(dest, seed, i, n, sk, lk);
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tuser  = tuser && b.l;
      s_axis_tvalid = 1'b1;
      if (push) exp_q.push_back(b);
      @(posedge clk156); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic mac_write(input int idx, input logic [47:0] addr, input logic v);
    mac_wr_en    = 1'b1;
    mac_wr_idx   = IDX_W'(idx);
    mac_wr_addr  = addr;
    mac_wr_valid = v;
    @(posedge clk156); #1;
    mac_wr_en    = 1'b0;
  endtask

  task automatic cmp_out(input string name);
    chk({name, " beat count"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s beat%0d", name, i), 128'({got[i].l, got[i].k, got[i].d}),
          128'({exp_q[i].l, exp_q[i].k, exp_q[i].d}));
    end
    got.delete();
    exp_q.delete();
  endtask

  // First output beat must appear within 3 cycles of the tlast beat
  task automatic chk_latency(input string name);
    bit seen = 1'b0;
    for (int i = 1; i <= 3 && !seen; i++) begin
      @(posedge clk156); #1;
      if (m_axis_tvalid) seen = 1'b1;
    end
    chk({name, " latency"}, 128'(seen), 128'(1));
  endtask

  int base_pkt;

  initial begin
    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; filter_en = 1'b1;
    mac_wr_en = 1'b0; mac_wr_idx = '0; mac_wr_addr = '0; mac_wr_valid = 1'b0;
    m_axis_tready = 1'b1;

    repeat (3) @(posedge clk156);
    #1;
    chk("reset tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("reset outputs", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(0));
    chk("reset rd_data_count", 128'(rd_data_count), 128'(0));
    chk("reset counters", 128'({pkt_cnt, drop_bad_cnt, drop_flt_cnt, drop_ovf_cnt}), 128'(0));
    aresetn = 1'b1;
    @(posedge clk156); #1;

    mac_write(0, E0, 1'b1);
    mac_write(1, E1, 1'b1);

    //         dest beats sofk   lastk  tuser fen   pass  pkt bad flt
    vecs[0] = '{E0, 8, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1, 0, 0};
    vecs[1] = '{EU, 8, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 0, 1};
    vecs[2] = '{E0, 9, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1, 1, 1};
    vecs[3] = '{E0, 8, 8'hFF, 8'h0F, 1'b0, 1'b1, 1'b1, 2, 1, 1};
    vecs[4] = '{E1, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 3, 1, 1};
    vecs[5] = '{E0, 3, 8'h1F, 8'hFF, 1'b0, 1'b1, 1'b0, 3, 2, 1};
    vecs[6] = '{EU, 3, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 4, 2, 1};
    vecs[7] = '{EU, 4, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 4, 3, 1};
    vecs[8] = '{EU, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 4, 3, 2};
`ifdef NIU_RX_BCAST_EN
    vecs[9] = '{BC, 8, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 5, 3, 2};
`else
    vecs[9] = '{BC, 8, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 4, 3, 3};
`endif

    for (int v = 0; v < 10; v++) begin
      filter_en = vecs[v].fen;
      send_frame(vecs[v].dest, vecs[v].beats, v, vecs[v].sof_keep, vecs[v].last_keep,
                 vecs[v].tuser, vecs[v].pass, vecs[v].beats);
      if (vecs[v].pass) chk_latency($sformatf("v%0d", v));
      repeat (vecs[v].beats + 8) @(posedge clk156);
      #1;
      cmp_out($sformatf("v%0d", v));
      chk($sformatf("v%0d pkt_cnt", v), 128'(pkt_cnt), 128'(vecs[v].pkt));
      chk($sformatf("v%0d drop_bad_cnt", v), 128'(drop_bad_cnt), 128'(vecs[v].bad));
      chk($sformatf("v%0d drop_flt_cnt", v), 128'(drop_flt_cnt), 128'(vecs[v].flt));
      chk($sformatf("v%0d drop_ovf_cnt", v), 128'(drop_ovf_cnt), 128'(0));
      chk($sformatf("v%0d rd_data_count", v), 128'(rd_data_count), 128'(0));
    end
    base_pkt  = vecs[9].pkt;
    filter_en = 1'b1;

    // Overflow: 10 beats committed, then a 10-beat frame that cannot fit is dropped
    m_axis_tready = 1'b0;
    send_frame(E0, 10, 20, 8'hFF, 8'hFF, 1'b0, 1'b1, 10);
    send_frame(E0, 10, 21, 8'hFF, 8'hFF, 1'b0, 1'b0, 10);
    repeat (4) @(posedge clk156);
    #1;
    chk("ovf rd_data_count", 128'(rd_data_count), 128'(10));
    chk("ovf drop_ovf_cnt", 128'(drop_ovf_cnt), 128'(1));
    chk("ovf pkt_cnt", 128'(pkt_cnt), 128'(base_pkt + 1));
    chk("ovf stalled tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("ovf stalled tdata", 128'(m_axis_tdata), 128'(exp_q[0].d));
    chk("ovf no beats while stalled", 128'(got.size()), 128'(0));
    m_axis_tready = 1'b1;
    repeat (30) @(posedge clk156);
    #1;
    cmp_out("ovf drain");
    chk("ovf rd_data_count drained", 128'(rd_data_count), 128'(0));

    // Frame that fills the buffer exactly, with nothing discarded, commits
    m_axis_tready = 1'b0;
    send_frame(E1, 16, 22, 8'hFF, 8'h03, 1'b0, 1'b1, 16);
    repeat (4) @(posedge clk156);
    #1;
    chk("full rd_data_count", 128'(rd_data_count), 128'(16));
    chk("full pkt_cnt", 128'(pkt_cnt), 128'(base_pkt + 2));
    chk("full drop_ovf_cnt", 128'(drop_ovf_cnt), 128'(1));
    m_axis_tready = 1'b1;
    repeat (40) @(posedge clk156);
    #1;
    cmp_out("full drain");

    // Reset in the middle of a frame with 5 beats written
    send_frame(E0, 8, 30, 8'hFF, 8'hFF, 1'b0, 1'b0, 5);
    aresetn = 1'b0;
    #2;
    chk("mid reset tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("mid reset outputs", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(0));
    chk("mid reset rd_data_count", 128'(rd_data_count), 128'(0));
    chk("mid reset counters", 128'({pkt_cnt, drop_bad_cnt, drop_flt_cnt, drop_ovf_cnt}), 128'(0));
    repeat (2) @(posedge clk156);
    #1;
    aresetn = 1'b1;
    got.delete();
    @(posedge clk156); #1;
    mac_write(0, E0, 1'b1);
    send_frame(E0, 8, 31, 8'hFF, 8'hFF, 1'b0, 1'b1, 8);
    chk_latency("post reset");
    repeat (16) @(posedge clk156);
    #1;
    cmp_out("post reset");
    chk("post reset pkt_cnt", 128'(pkt_cnt), 128'(1));
    chk("post reset rd_data_count", 128'(rd_data_count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
